parity_stream_merger: RTL and testbench

PARITY_STREAM_MERGER -- requirements
Module: parity_stream_merger

---
 rtl/parity_stream_merger.sv | 142 ++++++++++++++
 tb/tb_parity_stream_merger.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream_merger.sv
// Merges an odd-parity and an even-parity AXI-Stream byte source into one stream.
// Each input has its own FIFO; whole packets are forwarded, with alternating arbitration.
module parity_stream_merger #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             a_clk,
  input  logic             axis_aresetn,
  input  logic             axis_s_tvalid_odd,
  input  logic [7:0]       axis_s_tdata_odd,
  input  logic             axis_s_tlast_odd,
  output logic             axis_s_tready_odd,
  input  logic             axis_s_tvalid_even,
  input  logic [7:0]       axis_s_tdata_even,
  input  logic             axis_s_tlast_even,
  output logic             axis_s_tready_even,
  output logic             axis_m_tvalid,
  output logic [7:0]       axis_m_tdata,
  output logic             axis_m_tlast,
  output logic             axis_m_tuser,
  input  logic             axis_m_tready,
  output logic [CNT_W-1:0] pkt_cnt_odd,
  output logic [CNT_W-1:0] pkt_cnt_even
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT_ODD, GRANT_EVEN} state_t;

  // Index 1 = odd source, index 0 = even source (matches axis_m_tuser encoding).
  logic [1:0][8:0] s_word;
  logic [1:0][8:0] head;
  logic [1:0]      s_valid, s_ready, push, pop, empty;
  logic            ready_en;

  assign s_word  = {{axis_s_tlast_odd, axis_s_tdata_odd}, {axis_s_tlast_even, axis_s_tdata_even}};
  assign s_valid = {axis_s_tvalid_odd, axis_s_tvalid_even};
  assign push    = s_valid & s_ready;

  assign axis_s_tready_odd  = s_ready[1];
  assign axis_s_tready_even = s_ready[0];

  // Holds both tready low during reset and until the first edge after release.
  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) ready_en <= 1'b0;
    else               ready_en <= 1'b1;
  end

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    assign s_ready[g] = ready_en && (count != FULL);
    assign empty[g]   = (count == '0);
    assign head[g]    = mem[rd_ptr];

    always_ff @(posedge a_clk) begin
      if (push[g]) mem[wr_ptr] <= s_word[g];
    end

    always_ff @(posedge a_clk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + AW'(1);
        if (pop[g])  rd_ptr <= rd_ptr + AW'(1);
        case ({push[g], pop[g]})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  state_t     state, state_next;
  logic       last_grant;
  logic       grant_active, sel, load;
  logic [8:0] load_word;

  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!empty[1] && !empty[0]) state_next = last_grant ? GRANT_EVEN : GRANT_ODD;
        else if (!empty[1])         state_next = GRANT_ODD;
        else if (!empty[0])         state_next = GRANT_EVEN;
      end
      GRANT_ODD, GRANT_EVEN: begin
        if (load && load_word[8]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant_active = 1'b0;
    sel          = 1'b0;
    case (state)
      GRANT_ODD:  begin grant_active = 1'b1; sel = 1'b1; end
      GRANT_EVEN: begin grant_active = 1'b1; sel = 1'b0; end
      default:    ;
    endcase
    load      = grant_active && !empty[sel] && (!axis_m_tvalid || axis_m_tready);
    pop       = {load && sel, load && !sel};
    load_word = head[sel];
  end

  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      axis_m_tvalid <= 1'b0;
      axis_m_tdata  <= '0;
      axis_m_tlast  <= 1'b0;
      axis_m_tuser  <= 1'b0;
      pkt_cnt_odd   <= '0;
      pkt_cnt_even  <= '0;
      last_grant    <= 1'b1;
    end else if (load) begin
      axis_m_tvalid <= 1'b1;
      axis_m_tlast  <= load_word[8];
      axis_m_tdata  <= load_word[7:0];
      axis_m_tuser  <= sel;
      if (load_word[8]) begin
        last_grant <= sel;
        if (sel) pkt_cnt_odd  <= pkt_cnt_odd + CNT_W'(1);
        else     pkt_cnt_even <= pkt_cnt_even + CNT_W'(1);
      end
    end else if (axis_m_tready) begin
      axis_m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_stream_merger.sv
// Scoreboard bench for parity_stream_merger: directed packets, expected bytes queued
// at stimulus time and checked by an independent output monitor.
module tb_parity_stream_merger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        odd_valid, odd_last, odd_ready;
  logic [7:0]  odd_data;
  logic        even_valid, even_last, even_ready;
  logic [7:0]  even_data;
  logic        m_valid, m_last, m_user, m_ready;
  logic [7:0]  m_data;
  logic [15:0] cnt_odd, cnt_even;

  logic        w_valid, w_ready, w_even_ready, w_m_valid, w_m_last, w_m_user;
  logic [7:0]  w_data, w_m_data;
  logic [2:0]  w_cnt_odd, w_cnt_even;

  logic [9:0]  exp_q [$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned odd_acc = 0;

  always #5 clk = ~clk;

  parity_stream_merger #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .a_clk(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid_odd(odd_valid), .axis_s_tdata_odd(odd_data),
    .axis_s_tlast_odd(odd_last), .axis_s_tready_odd(odd_ready),
    .axis_s_tvalid_even(even_valid), .axis_s_tdata_even(even_data),
    .axis_s_tlast_even(even_last), .axis_s_tready_even(even_ready),
    .axis_m_tvalid(m_valid), .axis_m_tdata(m_data), .axis_m_tlast(m_last),
    .axis_m_tuser(m_user), .axis_m_tready(m_ready),
    .pkt_cnt_odd(cnt_odd), .pkt_cnt_even(cnt_even)
  );

  // Narrow-counter instance so counter wraparound is reachable in a short run.
  parity_stream_merger #(.FIFO_DEPTH(2), .CNT_W(3)) u_wrap (
    .a_clk(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid_odd(w_valid), .axis_s_tdata_odd(w_data),
    .axis_s_tlast_odd(1'b1), .axis_s_tready_odd(w_ready),
    .axis_s_tvalid_even(1'b0), .axis_s_tdata_even(8'h00),
    .axis_s_tlast_even(1'b0), .axis_s_tready_even(w_even_ready),
    .axis_m_tvalid(w_m_valid), .axis_m_tdata(w_m_data), .axis_m_tlast(w_m_last),
    .axis_m_tuser(w_m_user), .axis_m_tready(1'b1),
    .pkt_cnt_odd(w_cnt_odd), .pkt_cnt_even(w_cnt_even)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Output monitor: every presented byte must equal the queue head; pop on handshake.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got %h expected no output", {m_user, m_last, m_data});
      end else begin
        if ({m_user, m_last, m_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL out_byte: got user/last/data %h expected %h",
                   {m_user, m_last, m_data}, exp_q[0]);
        end
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic odd, input logic [7:0] d, input logic l);
    int unsigned n = 0;
    logic rdy;
    if (odd) begin odd_valid = 1'b1; odd_data = d; odd_last = l; end
    else     begin even_valid = 1'b1; even_data = d; even_last = l; end
    do begin
      @(negedge clk);
      n++;
      rdy = odd ? odd_ready : even_ready;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got tready 0 expected 1 (odd=%0d data %h)", odd, d);
    end
    @(posedge clk); #1;
    if (odd) begin odd_valid = 1'b0; odd_acc++; end
    else     even_valid = 1'b0;
  endtask

  task automatic wsend(input logic [7:0] d);
    int unsigned n = 0;
    w_valid = 1'b1;
    w_data  = d;
    do begin @(negedge clk); n++; end while (!w_ready && n < 100);
    if (!w_ready) begin
      checks++;
      errors++;
      $display("FAIL wrap_send_timeout: got tready 0 expected 1");
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_tvalid", {31'b0, m_valid}, 32'd0);
    check("rst_tdata_last_user", {22'b0, m_user, m_last, m_data}, 32'd0);
    check("rst_tready_odd", {31'b0, odd_ready}, 32'd0);
    check("rst_tready_even", {31'b0, even_ready}, 32'd0);
    check("rst_cnt", {cnt_odd, cnt_even}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_tready", {30'b0, odd_ready, even_ready}, 32'd3);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_left", exp_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    odd_valid = 1'b0; odd_data = '0; odd_last = 1'b0;
    even_valid = 1'b0; even_data = '0; even_last = 1'b0;
    m_ready = 1'b1;
    w_valid = 1'b0; w_data = '0;
    do_reset();

    // Single even packet: latency 2, back-to-back bytes.
    exp_q.push_back({1'b0, 1'b0, 8'h03});
    exp_q.push_back({1'b0, 1'b1, 8'h05});
    fork
      begin send(1'b0, 8'h03, 1'b0); send(1'b0, 8'h05, 1'b1); end
      begin
        @(negedge clk); check("lat_before_write", {31'b0, m_valid}, 32'd0);
        @(negedge clk); check("lat_after_e", {31'b0, m_valid}, 32'd0);
        @(negedge clk); check("lat_after_e1", {31'b0, m_valid}, 32'd0);
        @(negedge clk); check("lat_after_e2", {31'b0, m_valid}, 32'd1);
        @(negedge clk); check("thru_second_last", {30'b0, m_valid, m_last}, 32'd3);
      end
    join
    wait_drain();
    check("t1_cnt_even", {16'b0, cnt_even}, 32'd1);
    check("t1_cnt_odd", {16'b0, cnt_odd}, 32'd0);

    // Tie after reset grants even first, then odd.
    do_reset();
    exp_q.push_back({1'b0, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b1, 8'h12});
    exp_q.push_back({1'b1, 1'b0, 8'h21});
    exp_q.push_back({1'b1, 1'b1, 8'h22});
    fork
      begin send(1'b0, 8'h11, 1'b0); send(1'b0, 8'h12, 1'b1); end
      begin send(1'b1, 8'h21, 1'b0); send(1'b1, 8'h22, 1'b1); end
    join
    wait_drain();
    check("t2_cnts", {cnt_odd, cnt_even}, {16'd1, 16'd1});

    // Backpressure: 12-byte odd packet with downstream stalled for 20 cycles.
    for (int unsigned i = 0; i < 12; i++)
      exp_q.push_back({1'b1, (i == 11), 8'h40 + 8'(i)});
    m_ready = 1'b0;
    odd_acc = 0;
    fork
      begin
        for (int unsigned i = 0; i < 12; i++) send(1'b1, 8'h40 + 8'(i), (i == 11));
      end
      begin
        repeat (20) @(negedge clk);
        check("bp_accepted", odd_acc, 32'd9);
        check("bp_tready_odd", {31'b0, odd_ready}, 32'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_drain();
    check("t3_cnt_odd", {16'b0, cnt_odd}, 32'd2);

    // Odd packet stalls mid-packet; waiting even packet must not interleave.
    exp_q.push_back({1'b1, 1'b0, 8'h61});
    exp_q.push_back({1'b1, 1'b0, 8'h62});
    exp_q.push_back({1'b1, 1'b1, 8'h63});
    exp_q.push_back({1'b0, 1'b0, 8'h71});
    exp_q.push_back({1'b0, 1'b1, 8'h72});
    fork
      begin
        send(1'b1, 8'h61, 1'b0);
        send(1'b1, 8'h62, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send(1'b1, 8'h63, 1'b1);
      end
      begin
        @(posedge clk); #1;
        send(1'b0, 8'h71, 1'b0);
        send(1'b0, 8'h72, 1'b1);
      end
    join
    wait_drain();
    check("t4_cnts", {cnt_odd, cnt_even}, {16'd3, 16'd2});

    // Reset mid-packet discards everything buffered.
    m_ready = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 8'h81});
    exp_q.push_back({1'b1, 1'b0, 8'h82});
    send(1'b1, 8'h81, 1'b0);
    send(1'b1, 8'h82, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    m_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_output", {31'b0, m_valid}, 32'd0);
    end
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 1'b0, 8'h91});
    exp_q.push_back({1'b0, 1'b1, 8'h92});
    send(1'b0, 8'h91, 1'b0);
    send(1'b0, 8'h92, 1'b1);
    wait_drain();
    check("t5_cnts", {cnt_odd, cnt_even}, {16'd0, 16'd1});

    // Counter wraparound on the 3-bit instance.
    for (int unsigned i = 0; i < 7; i++) wsend(8'(i));
    repeat (6) @(negedge clk);
    check("wrap_cnt_7", {29'b0, w_cnt_odd}, 32'd7);
    @(posedge clk); #1;
    wsend(8'hA7);
    repeat (6) @(negedge clk);
    check("wrap_cnt_0", {29'b0, w_cnt_odd}, 32'd0);
    check("wrap_cnt_even", {29'b0, w_cnt_even}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
